nes_ppu: RTL and testbench
==========================

// Module: nes_ppu
// PURPOSE
//  NES picture processing unit core: CPU-visible register file ($2000-$2007), 341x262 dot
//  timing, vblank flag / NMI, VRAM access port, 32-entry palette and 256-byte OAM.
//  Sits between the CPU bus decoder and VRAM/CHR memory; drives a backdrop-colour video stream.
// PARAMETERS
//  DOTS_PER_LINE   341  dots per scanline (0..340)
//  LINES_PER_FRAME 262  scanlines per frame (0..261)
// PORTS
//  CLK              in   1   PPU dot clock; sole clock, everything rising-edge
//  RESET_n          in   1   asynchronous, active-low reset
//  ENABLE           in   1   1 = dot/scanline counters advance; register access unaffected
//  CPU_ADDR         in   3   register select (0..7 = $2000..$2007)
//  CPU_DATA_IN      in   8   CPU write data
//  CPU_wren         in   1   write request (level, may span several CLK)
//  CPU_rden         in   1   read request (level, may span several CLK)
//  CPU_DATA_OUT     out  8   read data
//  NMI_n            out  1   active-low NMI to CPU
//  debug_enable_nmi in   1   global NMI gate (0 = never assert NMI)
//  PPU_DATA_IN      in   8   VRAM read data, valid 1 CLK after PPU_READ
//  PPU_DATA_OUT     out  8   VRAM write data
//  PPU_ADDR         out  14  VRAM address (= v register)
//  PPU_WRITE        out  1   1-CLK VRAM write strobe
//  PPU_READ         out  1   1-CLK VRAM read strobe
//  VGA_HS, VGA_VS   out  1   active-low syncs
//  VGA_R/G/B        out  4   colour per channel
// BEHAVIOUR
//  Reset: all registers, v, t, x, w, counters, OAM address = 0; CPU_DATA_OUT=0, NMI_n=1,
//   PPU_WRITE=PPU_READ=0, PPU_DATA_OUT=0, VGA_HS=VGA_VS=1, RGB=0. Palette/OAM contents undefined.
//  Access detect: act once per rising edge of CPU_wren/CPU_rden (registered previous value);
//   held level never repeats. Both edges same cycle: write only.
//  Counters: dot 0..340 then wrap, scanline +1; scanline 261 wraps to 0. Frozen when ENABLE=0.
//  vblank: set at scanline 241 dot 1; cleared at scanline 261 dot 1 or by $2002 read.
//   $2002 read same cycle as set: returns old bit (0); set still takes effect.
//  NMI_n = ~(vblank & PPUCTRL[7] & debug_enable_nmi), combinational from registered bits.
//  $2000 write: PPUCTRL <= data; t[11:10] <= data[1:0]. Increment = PPUCTRL[2] ? 32 : 1.
//  $2001 write: PPUMASK <= data. $2003 write: OAMADDR <= data.
//  $2002 read: CPU_DATA_OUT <= {vblank,2'b00,5'b0}; clear vblank and w.
//  $2004 write: OAM[OAMADDR] <= data, OAMADDR+1 (8-bit wrap); read returns OAM[OAMADDR].
//  $2005 write: w=0 -> x<=d[2:0], t[4:0]<=d[7:3], w=1; w=1 -> t[14:12]<=d[2:0], t[9:5]<=d[7:3], w=0.
//  $2006 write: w=0 -> t[13:8]<=d[5:0], t[14]<=0, w=1; w=1 -> t[7:0]<=d, v<=t (new), w=0.
//  $2007 write: v[13:8]==6'h3F -> palette[v[4:0]] <= d[5:0], no bus cycle; else PPU_ADDR=v,
//   PPU_DATA_OUT=d, PPU_WRITE high 1 CLK. Then v += increment (15-bit wrap).
//  $2007 read: CPU_DATA_OUT <= read buffer (palette: direct palette value, 2'b00 on top);
//   PPU_READ 1 CLK at v, next CLK buffer <= PPU_DATA_IN; then v += increment.
//  Palette mirroring: indices $10/$14/$18/$1C alias $00/$04/$08/$0C.
//  Write-only register reads return last CPU_DATA_OUT (open bus). CPU_DATA_OUT registered, valid
//   1 CLK after read edge, held until next read.
//  Video: visible = scanline 0..239, dot 1..256. Visible & PPUMASK[3]: p=palette[0],
//   R={p[5:4],p[5:4]}, G={p[3:2],p[3:2]}, B={p[1:0],p[1:0]}; otherwise RGB=0.
//   VGA_HS low dots 277..301; VGA_VS low scanlines 245..247. All outputs registered.
//  Reset mid-access: pending strobes/buffer loads abandoned; outputs return to reset values.
// TESTING
//  Reset low 5 CLK, release; write $2000=8'h80 -> NMI_n=1 until scanline 241 dot 1, then 0.
//  At vblank read $2002 -> CPU_DATA_OUT=8'h80, vblank cleared, NMI_n=1; second read -> 8'h00.
//  $2006 <= 8'h21 then 8'h08 (3-CLK wren pulses) -> PPU_ADDR=14'h2108; single action per pulse.
//  $2000=0, $2007 <= 8'h55 -> PPU_WRITE 1 CLK at 14'h2108, data 8'h55, then v=14'h2109;
//   with $2000=8'h04 -> v=14'h2128.
//  $2006=3F,10; $2007<=8'h2A; $2006=3F,00; read $2007 -> 8'h2A; PPUMASK=8'h08 -> R=4'hA,G=4'hA,B=4'hA.
//  debug_enable_nmi=0 with PPUCTRL[7]=1 through vblank -> NMI_n stays 1.

Source files
------------

// File: rtl/nes_ppu_if.sv
// CPU-side register bus of the PPU ($2000-$2007).
// master = CPU bus decoder, slave = PPU core; read data and NMI_n flow back to the CPU.
interface nes_ppu_if;
    logic [2:0] CPU_ADDR;
    logic [7:0] CPU_DATA_IN;
    logic       CPU_wren;
    logic       CPU_rden;
    logic [7:0] CPU_DATA_OUT;
    logic       NMI_n;

    modport master (
        output CPU_ADDR, CPU_DATA_IN, CPU_wren, CPU_rden,
        input  CPU_DATA_OUT, NMI_n
    );

    modport slave (
        input  CPU_ADDR, CPU_DATA_IN, CPU_wren, CPU_rden,
        output CPU_DATA_OUT, NMI_n
    );
endinterface

// File: rtl/nes_ppu.sv
// NES PPU core: $2000-$2007 registers, 341x262 dot timing, vblank/NMI, VRAM port,
// 32-entry palette, 256-byte OAM and a backdrop-colour video stream.
// Ports: CLK, RESET_n (async low), ENABLE (counter advance), cpu (register bus),
//   debug_enable_nmi, PPU_DATA_IN/OUT, PPU_ADDR, PPU_WRITE/READ strobes,
//   VGA_HS/VS (active low), VGA_R/G/B.
module nes_ppu #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        ENABLE,
    nes_ppu_if.slave    cpu,
    input  logic        debug_enable_nmi,
    input  logic [7:0]  PPU_DATA_IN,
    output logic [7:0]  PPU_DATA_OUT,
    output logic [13:0] PPU_ADDR,
    output logic        PPU_WRITE,
    output logic        PPU_READ,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic [3:0]  VGA_R,
    output logic [3:0]  VGA_G,
    output logic [3:0]  VGA_B
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RDW} st_t;

    st_t         state;
    logic        wren_q, rden_q;
    logic [8:0]  dot, line;
    logic        vblank;
    logic [7:0]  ctrl, mask, oam_addr, rbuf;
    logic [14:0] v, t;
    logic [2:0]  x;
    logic        w;
    logic [5:0]  pal [32];
    logic [7:0]  oam [256];

    logic        wr_edge, rd_edge, pal_hit, set_vb, clr_vb, vis;
    logic [4:0]  pal_idx;
    logic [14:0] inc;
    logic [7:0]  d;
    logic        unused_ok;

    assign d       = cpu.CPU_DATA_IN;
    assign wr_edge = cpu.CPU_wren & ~wren_q;
    // a write wins when both requests rise together
    assign rd_edge = cpu.CPU_rden & ~rden_q & ~wr_edge;
    assign pal_hit = (v[13:8] == 6'h3F);
    // sprite backdrop entries $10/$14/$18/$1C share storage with $00/$04/$08/$0C
    assign pal_idx = (v[4] && v[1:0] == 2'b00) ? {1'b0, v[3:0]} : v[4:0];
    assign inc     = ctrl[2] ? 15'd32 : 15'd1;
    assign set_vb  = ENABLE && line == 9'd241 && dot == 9'd1;
    assign clr_vb  = ENABLE && line == 9'd261 && dot == 9'd1;
    assign vis     = line < 9'd240 && dot >= 9'd1 && dot <= 9'd256;

    assign PPU_ADDR  = v[13:0];
    assign cpu.NMI_n = ~(vblank & ctrl[7] & debug_enable_nmi);
    assign unused_ok = ^{x, ctrl[6:3], ctrl[1:0], mask[7:4], mask[2:0]};

    always_ff @(posedge CLK) begin
        if (wr_edge && cpu.CPU_ADDR == 3'd7 && pal_hit)
            pal[pal_idx] <= d[5:0];
        if (wr_edge && cpu.CPU_ADDR == 3'd4)
            oam[oam_addr] <= d;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state            <= S_IDLE;
            wren_q           <= 1'b0;
            rden_q           <= 1'b0;
            dot              <= '0;
            line             <= '0;
            vblank           <= 1'b0;
            ctrl             <= '0;
            mask             <= '0;
            oam_addr         <= '0;
            rbuf             <= '0;
            v                <= '0;
            t                <= '0;
            x                <= '0;
            w                <= 1'b0;
            cpu.CPU_DATA_OUT <= '0;
            PPU_DATA_OUT     <= '0;
            PPU_WRITE        <= 1'b0;
            PPU_READ         <= 1'b0;
            VGA_HS           <= 1'b1;
            VGA_VS           <= 1'b1;
            VGA_R            <= '0;
            VGA_G            <= '0;
            VGA_B            <= '0;
        end else begin
            wren_q    <= cpu.CPU_wren;
            rden_q    <= cpu.CPU_rden;
            PPU_WRITE <= 1'b0;
            PPU_READ  <= 1'b0;

            if (ENABLE) begin
                if (dot == 9'(DOTS_PER_LINE - 1)) begin
                    dot  <= '0;
                    line <= (line == 9'(LINES_PER_FRAME - 1)) ? 9'd0 : line + 9'd1;
                end else begin
                    dot <= dot + 9'd1;
                end
            end

            // VRAM cycle sequencing: address advances only after the strobe/data cycle
            unique case (state)
                S_WR: begin
                    v     <= v + inc;
                    state <= S_IDLE;
                end
                S_RD:  state <= S_RDW;
                S_RDW: begin
                    rbuf  <= PPU_DATA_IN;
                    v     <= v + inc;
                    state <= S_IDLE;
                end
                default: ;
            endcase

            if (wr_edge) begin
                case (cpu.CPU_ADDR)
                    3'd0: begin
                        ctrl      <= d;
                        t[11:10]  <= d[1:0];
                    end
                    3'd1: mask     <= d;
                    3'd3: oam_addr <= d;
                    3'd4: oam_addr <= oam_addr + 8'd1;
                    3'd5: begin
                        if (!w) begin
                            x      <= d[2:0];
                            t[4:0] <= d[7:3];
                        end else begin
                            t[14:12] <= d[2:0];
                            t[9:5]   <= d[7:3];
                        end
                        w <= ~w;
                    end
                    3'd6: begin
                        if (!w) begin
                            t[13:8] <= d[5:0];
                            t[14]   <= 1'b0;
                        end else begin
                            t[7:0] <= d;
                            v      <= {t[14:8], d};
                        end
                        w <= ~w;
                    end
                    3'd7: begin
                        if (pal_hit) begin
                            v <= v + inc;
                        end else begin
                            PPU_DATA_OUT <= d;
                            PPU_WRITE    <= 1'b1;
                            state        <= S_WR;
                        end
                    end
                    default: ;
                endcase
            end

            if (rd_edge) begin
                case (cpu.CPU_ADDR)
                    3'd2: begin
                        cpu.CPU_DATA_OUT <= {vblank, 7'b0};
                        w                <= 1'b0;
                    end
                    3'd4: cpu.CPU_DATA_OUT <= oam[oam_addr];
                    3'd7: begin
                        cpu.CPU_DATA_OUT <= pal_hit ? {2'b00, pal[pal_idx]} : rbuf;
                        PPU_READ         <= 1'b1;
                        state            <= S_RD;
                    end
                    default: ;
                endcase
            end

            // set is evaluated last so it beats a same-cycle $2002 clear
            if (rd_edge && cpu.CPU_ADDR == 3'd2)
                vblank <= 1'b0;
            if (clr_vb)
                vblank <= 1'b0;
            if (set_vb)
                vblank <= 1'b1;

            if (vis && mask[3]) begin
                VGA_R <= {pal[0][5:4], pal[0][5:4]};
                VGA_G <= {pal[0][3:2], pal[0][3:2]};
                VGA_B <= {pal[0][1:0], pal[0][1:0]};
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
            VGA_HS <= ~(dot >= 9'd277 && dot <= 9'd301);
            VGA_VS <= ~(line >= 9'd245 && line <= 9'd247);
        end
    end

endmodule

// File: tb/tb_nes_ppu.sv
// Scoreboard bench for nes_ppu: CPU reads and VRAM writes are queued by the driver
// and checked by an independent monitor; register/video/NMI state is checked inline.
module tb_nes_ppu;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        ENABLE = 1'b1;
    logic        debug_enable_nmi = 1'b1;
    logic [7:0]  PPU_DATA_IN = 8'h00;
    logic [7:0]  PPU_DATA_OUT;
    logic [13:0] PPU_ADDR;
    logic        PPU_WRITE, PPU_READ, VGA_HS, VGA_VS;
    logic [3:0]  VGA_R, VGA_G, VGA_B;

    nes_ppu_if bus ();

    nes_ppu dut (
        .CLK              (CLK),
        .RESET_n          (RESET_n),
        .ENABLE           (ENABLE),
        .cpu              (bus),
        .debug_enable_nmi (debug_enable_nmi),
        .PPU_DATA_IN      (PPU_DATA_IN),
        .PPU_DATA_OUT     (PPU_DATA_OUT),
        .PPU_ADDR         (PPU_ADDR),
        .PPU_WRITE        (PPU_WRITE),
        .PPU_READ         (PPU_READ),
        .VGA_HS           (VGA_HS),
        .VGA_VS           (VGA_VS),
        .VGA_R            (VGA_R),
        .VGA_G            (VGA_G),
        .VGA_B            (VGA_B)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  rq [$];
    logic [21:0] wq [$];
    logic [7:0]  mem [16384];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // VRAM model: read data valid one CLK after PPU_READ
    always @(posedge CLK) begin
        if (PPU_WRITE) mem[PPU_ADDR] <= PPU_DATA_OUT;
        if (PPU_READ)  PPU_DATA_IN <= mem[PPU_ADDR];
    end

    // dot position tracker: edges seen with ENABLE high since reset release
    always @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n)    cyc <= 0;
        else if (ENABLE) cyc <= cyc + 1;
    end

    logic rd_prev = 1'b0;
    logic rd_rise = 1'b0;
    always @(posedge CLK) begin
        rd_rise <= bus.CPU_rden & ~rd_prev;
        rd_prev <= bus.CPU_rden;
    end

    // monitor
    always @(negedge CLK) begin
        if (RESET_n && rd_rise) begin
            if (rq.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                logic [7:0] e;
                e = rq.pop_front();
                check("cpu_rd_data", {24'd0, bus.CPU_DATA_OUT}, {24'd0, e});
            end
        end
        if (RESET_n && PPU_WRITE) begin
            if (wq.size() == 0) begin
                check("vram_wr_unexpected", 32'd1, 32'd0);
            end else begin
                logic [21:0] e;
                e = wq.pop_front();
                check("vram_wr_addr", {18'd0, PPU_ADDR}, {18'd0, e[21:8]});
                check("vram_wr_data", {24'd0, PPU_DATA_OUT}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] dv);
        @(negedge CLK);
        bus.CPU_ADDR    = a;
        bus.CPU_DATA_IN = dv;
        bus.CPU_wren    = 1'b1;
        repeat (3) @(negedge CLK);
        bus.CPU_wren = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic cpu_rd(input logic [2:0] a, input logic [7:0] exp);
        rq.push_back(exp);
        @(negedge CLK);
        bus.CPU_ADDR = a;
        bus.CPU_rden = 1'b1;
        repeat (3) @(negedge CLK);
        bus.CPU_rden = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        bus.CPU_ADDR    = 3'd0;
        bus.CPU_DATA_IN = 8'h00;
        bus.CPU_wren    = 1'b0;
        bus.CPU_rden    = 1'b0;
        repeat (5) @(negedge CLK);

        check("rst_data_out", {24'd0, bus.CPU_DATA_OUT}, 32'h0);
        check("rst_nmi", {31'd0, bus.NMI_n}, 32'd1);
        check("rst_wr", {31'd0, PPU_WRITE}, 32'd0);
        check("rst_rd", {31'd0, PPU_READ}, 32'd0);
        check("rst_addr", {18'd0, PPU_ADDR}, 32'h0);
        check("rst_vdata", {24'd0, PPU_DATA_OUT}, 32'h0);
        check("rst_sync", {30'd0, VGA_HS, VGA_VS}, 32'd3);
        check("rst_rgb", {20'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
        RESET_n = 1'b1;

        // $2006 pair, each a 3-CLK pulse
        cpu_wr(3'd6, 8'h21);
        check("v_after_hi", {18'd0, PPU_ADDR}, 32'h0);
        cpu_wr(3'd6, 8'h08);
        check("v_2108", {18'd0, PPU_ADDR}, 32'h2108);

        cpu_wr(3'd0, 8'h00);
        wq.push_back({14'h2108, 8'h55});
        cpu_wr(3'd7, 8'h55);
        check("v_inc1", {18'd0, PPU_ADDR}, 32'h2109);

        cpu_wr(3'd6, 8'h21);
        cpu_wr(3'd6, 8'h08);
        cpu_wr(3'd0, 8'h04);
        wq.push_back({14'h2108, 8'h66});
        cpu_wr(3'd7, 8'h66);
        check("v_inc32", {18'd0, PPU_ADDR}, 32'h2128);

        // buffered $2007 reads
        cpu_wr(3'd0, 8'h00);
        cpu_wr(3'd6, 8'h21);
        cpu_wr(3'd6, 8'h08);
        cpu_rd(3'd7, 8'h00);
        check("v_after_rd", {18'd0, PPU_ADDR}, 32'h2109);
        cpu_rd(3'd7, 8'h66);

        // OAM
        cpu_wr(3'd3, 8'h10);
        cpu_wr(3'd4, 8'hAB);
        cpu_wr(3'd4, 8'hCD);
        cpu_wr(3'd3, 8'h10);
        cpu_rd(3'd4, 8'hAB);
        cpu_rd(3'd4, 8'hAB);
        cpu_wr(3'd3, 8'h11);
        cpu_rd(3'd4, 8'hCD);

        // palette write via mirror $3F10, read back at $3F00
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd6, 8'h10);
        cpu_wr(3'd7, 8'h2A);
        check("v_pal_inc", {18'd0, PPU_ADDR}, 32'h3F11);
        cpu_wr(3'd6, 8'h3F);
        cpu_wr(3'd6, 8'h00);
        cpu_rd(3'd7, 8'h2A);

        // open bus on write-only register
        cpu_rd(3'd1, 8'h2A);
        cpu_rd(3'd2, 8'h00);

        // backdrop video
        cpu_wr(3'd1, 8'h08);
        while (((cyc - 1) % 341) != 100) @(negedge CLK);
        check("rgb_visible", {20'd0, VGA_R, VGA_G, VGA_B}, 32'hAAA);
        check("hs_high", {31'd0, VGA_HS}, 32'd1);
        while (((cyc - 1) % 341) != 290) @(negedge CLK);
        check("rgb_blank", {20'd0, VGA_R, VGA_G, VGA_B}, 32'h0);
        check("hs_low", {31'd0, VGA_HS}, 32'd0);

        // counters freeze while ENABLE low
        ENABLE = 1'b0;
        repeat (20) @(negedge CLK);
        ENABLE = 1'b1;

        cpu_wr(3'd0, 8'h80);
        check("nmi_before", {31'd0, bus.NMI_n}, 32'd1);
        while (cyc < 241 * 341 + 1) @(negedge CLK);
        check("nmi_at_241_1", {31'd0, bus.NMI_n}, 32'd1);
        debug_enable_nmi = 1'b0;
        repeat (4) @(negedge CLK);
        check("nmi_gated", {31'd0, bus.NMI_n}, 32'd1);
        check("vs_high", {31'd0, VGA_VS}, 32'd1);
        debug_enable_nmi = 1'b1;
        #1;
        check("nmi_asserted", {31'd0, bus.NMI_n}, 32'd0);
        cpu_rd(3'd2, 8'h80);
        check("nmi_cleared", {31'd0, bus.NMI_n}, 32'd1);
        cpu_rd(3'd2, 8'h00);

        repeat (2) @(negedge CLK);
        check("rq_empty", rq.size(), 32'd0);
        check("wq_empty", wq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
